// File: rtl/hough_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : hough_pkg                                                    |
// | Description : Shared constants, the scan state encoding and the per-lane  |
// |               peak record used by hough_peak_select and peak_tracker.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package hough_pkg;

  // Accumulator geometry: 1 degree per theta bin, rho spans -RHO_MAX..+RHO_MAX.
  localparam int THETAS   = 180;
  localparam int RHO_MAX  = 1468;
  localparam int NUM_RHOS = 2 * RHO_MAX + 1;

  // Datapath widths. lane_peak_t is built from these, so instances must use
  // the same ACCUM_BITS / THETA_BITS values.
  localparam int ACCUM_BITS = 16;
  localparam int THETA_BITS = 9;
  localparam int RHO_BITS   = 16;

  // Inclusive lane windows and the acceptance threshold.
  localparam int LEFT_THETA_MIN  = 10;
  localparam int LEFT_THETA_MAX  = 60;
  localparam int RIGHT_THETA_MIN = 120;
  localparam int RIGHT_THETA_MAX = 170;
  localparam int MIN_VOTES       = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

  typedef struct packed {
    logic [ACCUM_BITS-1:0]      votes;
    logic signed [RHO_BITS-1:0] rho;
    logic [THETA_BITS-1:0]      theta;
    logic                       valid;
  } lane_peak_t;

endpackage
`default_nettype wire

// File: rtl/peak_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : peak_tracker                                                 |
// | Description : Running maximum of accumulator samples whose theta falls in |
// |               [WIN_MIN, WIN_MAX]. Strict comparison keeps the first       |
// |               occurrence on a tie.                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clock        in  : rising-edge clock                                     |
// |   reset        in  : asynchronous active-low reset                         |
// |   clear        in  : drop the running best (start of a new scan)          |
// |   sample_valid in  : sample_* carries a returned accumulator word         |
// |   sample_votes in  : vote count                                           |
// |   sample_rho   in  : signed rho of the sample                             |
// |   sample_theta in  : theta of the sample                                  |
// |   result       out : running best including the sample presented now     |
// +----------------------------------------------------------------------------+
module peak_tracker
  import hough_pkg::*;
#(
  parameter int WIN_MIN  = LEFT_THETA_MIN,
  parameter int WIN_MAX  = LEFT_THETA_MAX,
  parameter int VOTE_MIN = MIN_VOTES
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       sample_valid,
  input  logic [ACCUM_BITS-1:0]      sample_votes,
  input  logic signed [RHO_BITS-1:0] sample_rho,
  input  logic [THETA_BITS-1:0]      sample_theta,
  output lane_peak_t                 result
);

  lane_peak_t best_q;
  lane_peak_t best_d;
  logic       in_window;
  logic       better;

  always_comb begin
    in_window = (int'(sample_theta) >= WIN_MIN) && (int'(sample_theta) <= WIN_MAX);
    better    = sample_valid && in_window &&
                (sample_votes > best_q.votes) &&
                (int'(sample_votes) >= VOTE_MIN);
    best_d = best_q;
    if (clear) begin
      best_d = '0;
    end else if (better) begin
      best_d.votes = sample_votes;
      best_d.rho   = sample_rho;
      best_d.theta = sample_theta;
      best_d.valid = 1'b1;
    end
  end

  // Exposing the next-state value lets the top latch the result on the same
  // edge that folds in the final sample of the scan.
  assign result = best_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      best_q <= '0;
    end else begin
      best_q <= best_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hough_peak_select.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hough_peak_select                                            |
// | Description : Scans the Hough accumulator after voting and reports the    |
// |               strongest line in the left and right lane theta windows.    |
// |               Optional macro HOUGH_PEAK_CLEAR_EN zeroes each word right   |
// |               after it has been read (needs a dual-port accumulator).     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clock / reset          : rising-edge clock, async active-low reset      |
// |   accum_done             : one-cycle pulse, voting finished               |
// |   accum_rd_addr/_data    : accumulator read, data 1 cycle after address   |
// |   accum_wr_en/_addr/_data: clear-as-you-scan write port (0 when disabled)|
// |   left_/right_rho_out    : signed rho = rho_idx - RHO_MAX                 |
// |   left_/right_theta_out  : selected theta                                 |
// |   left_/right_valid      : a peak >= MIN_VOTES was found                  |
// |   busy                   : scan in progress                              |
// |   hough_done             : one-cycle pulse, results valid                 |
// +----------------------------------------------------------------------------+
module hough_peak_select #(
  parameter int THETAS          = hough_pkg::THETAS,
  parameter int RHO_MAX         = hough_pkg::RHO_MAX,
  parameter int ACCUM_BITS      = hough_pkg::ACCUM_BITS,
  parameter int THETA_BITS      = hough_pkg::THETA_BITS,
  parameter int LEFT_THETA_MIN  = hough_pkg::LEFT_THETA_MIN,
  parameter int LEFT_THETA_MAX  = hough_pkg::LEFT_THETA_MAX,
  parameter int RIGHT_THETA_MIN = hough_pkg::RIGHT_THETA_MIN,
  parameter int RIGHT_THETA_MAX = hough_pkg::RIGHT_THETA_MAX,
  parameter int MIN_VOTES       = hough_pkg::MIN_VOTES,
  parameter int ADDR_BITS       = $clog2((2 * RHO_MAX + 1) * THETAS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  accum_done,
  output logic [ADDR_BITS-1:0]  accum_rd_addr,
  input  logic [ACCUM_BITS-1:0] accum_rd_data,
  output logic                  accum_wr_en,
  output logic [ADDR_BITS-1:0]  accum_wr_addr,
  output logic [ACCUM_BITS-1:0] accum_wr_data,
  output logic signed [15:0]    left_rho_out,
  output logic signed [15:0]    right_rho_out,
  output logic [THETA_BITS-1:0] left_theta_out,
  output logic [THETA_BITS-1:0] right_theta_out,
  output logic                  left_valid,
  output logic                  right_valid,
  output logic                  busy,
  output logic                  hough_done
);

  import hough_pkg::*;

  localparam int NUM_RHOS     = 2 * RHO_MAX + 1;
  localparam int RHO_IDX_BITS = $clog2(NUM_RHOS);

  scan_state_e state_q, state_d;

  // Issue-side scan counters; the linear address runs alongside so no
  // multiplier is needed for rho_idx * THETAS + theta.
  logic [RHO_IDX_BITS-1:0] rho_idx_q, rho_idx_d;
  logic [THETA_BITS-1:0]   theta_q, theta_d;
  logic [ADDR_BITS-1:0]    addr_q, addr_d;

  // Issued coordinates delayed one cycle to line up with accum_rd_data.
  logic                    smp_valid_q, smp_valid_d;
  logic [RHO_IDX_BITS-1:0] smp_rho_idx_q, smp_rho_idx_d;
  logic [THETA_BITS-1:0]   smp_theta_q, smp_theta_d;
  logic [ADDR_BITS-1:0]    smp_addr_q, smp_addr_d;

  logic signed [15:0]      left_rho_q, left_rho_d;
  logic signed [15:0]      right_rho_q, right_rho_d;
  logic [THETA_BITS-1:0]   left_theta_q, left_theta_d;
  logic [THETA_BITS-1:0]   right_theta_q, right_theta_d;
  logic                    left_valid_q, left_valid_d;
  logic                    right_valid_q, right_valid_d;

  logic                    tracker_clear;
  logic                    last_addr;
  logic signed [15:0]      smp_rho;
  lane_peak_t              left_res;
  lane_peak_t              right_res;

  assign smp_rho = 16'(smp_rho_idx_q) - 16'(RHO_MAX);

  always_comb begin
    state_d        = state_q;
    rho_idx_d      = '0;
    theta_d        = '0;
    addr_d         = '0;
    smp_valid_d    = 1'b0;
    smp_rho_idx_d  = rho_idx_q;
    smp_theta_d    = theta_q;
    smp_addr_d     = addr_q;
    tracker_clear  = 1'b0;
    left_rho_d     = left_rho_q;
    right_rho_d    = right_rho_q;
    left_theta_d   = left_theta_q;
    right_theta_d  = right_theta_q;
    left_valid_d   = left_valid_q;
    right_valid_d  = right_valid_q;
    last_addr      = (rho_idx_q == RHO_IDX_BITS'(NUM_RHOS - 1)) &&
                     (theta_q == THETA_BITS'(THETAS - 1));

    case (state_q)
      ST_IDLE: begin
        if (accum_done) begin
          state_d       = ST_SCAN;
          tracker_clear = 1'b1;
        end
      end
      ST_SCAN: begin
        smp_valid_d = 1'b1;
        if (last_addr) begin
          state_d = ST_DRAIN;
        end else begin
          addr_d = addr_q + 1'b1;
          if (theta_q == THETA_BITS'(THETAS - 1)) begin
            theta_d   = '0;
            rho_idx_d = rho_idx_q + 1'b1;
          end else begin
            theta_d   = theta_q + 1'b1;
            rho_idx_d = rho_idx_q;
          end
        end
      end
      ST_DRAIN: begin
        // Trackers present the final sample folded in, so outputs land in
        // the DONE cycle together with hough_done.
        state_d       = ST_DONE;
        left_rho_d    = left_res.rho;
        left_theta_d  = left_res.theta;
        left_valid_d  = left_res.valid;
        right_rho_d   = right_res.rho;
        right_theta_d = right_res.theta;
        right_valid_d = right_res.valid;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      rho_idx_q     <= '0;
      theta_q       <= '0;
      addr_q        <= '0;
      smp_valid_q   <= 1'b0;
      smp_rho_idx_q <= '0;
      smp_theta_q   <= '0;
      smp_addr_q    <= '0;
      left_rho_q    <= '0;
      right_rho_q   <= '0;
      left_theta_q  <= '0;
      right_theta_q <= '0;
      left_valid_q  <= 1'b0;
      right_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rho_idx_q     <= rho_idx_d;
      theta_q       <= theta_d;
      addr_q        <= addr_d;
      smp_valid_q   <= smp_valid_d;
      smp_rho_idx_q <= smp_rho_idx_d;
      smp_theta_q   <= smp_theta_d;
      smp_addr_q    <= smp_addr_d;
      left_rho_q    <= left_rho_d;
      right_rho_q   <= right_rho_d;
      left_theta_q  <= left_theta_d;
      right_theta_q <= right_theta_d;
      left_valid_q  <= left_valid_d;
      right_valid_q <= right_valid_d;
    end
  end

  peak_tracker #(
    .WIN_MIN  (LEFT_THETA_MIN),
    .WIN_MAX  (LEFT_THETA_MAX),
    .VOTE_MIN (MIN_VOTES)
  ) u_left_tracker (
    .clock        (clock),
    .reset        (reset),
    .clear        (tracker_clear),
    .sample_valid (smp_valid_q),
    .sample_votes (accum_rd_data),
    .sample_rho   (smp_rho),
    .sample_theta (smp_theta_q),
    .result       (left_res)
  );

  peak_tracker #(
    .WIN_MIN  (RIGHT_THETA_MIN),
    .WIN_MAX  (RIGHT_THETA_MAX),
    .VOTE_MIN (MIN_VOTES)
  ) u_right_tracker (
    .clock        (clock),
    .reset        (reset),
    .clear        (tracker_clear),
    .sample_valid (smp_valid_q),
    .sample_votes (accum_rd_data),
    .sample_rho   (smp_rho),
    .sample_theta (smp_theta_q),
    .result       (right_res)
  );

  assign accum_rd_addr   = addr_q;
  assign busy            = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
  assign hough_done      = (state_q == ST_DONE);
  assign left_rho_out    = left_rho_q;
  assign right_rho_out   = right_rho_q;
  assign left_theta_out  = left_theta_q;
  assign right_theta_out = right_theta_q;
  assign left_valid      = left_valid_q;
  assign right_valid     = right_valid_q;

  // Vote counts of the winners are only needed inside the trackers.
  logic unused_bits;

`ifdef HOUGH_PEAK_CLEAR_EN
  // Each word is zeroed in the cycle its data returns; that address has
  // already been read, so a dual-port accumulator sees no hazard.
  assign accum_wr_en   = smp_valid_q;
  assign accum_wr_addr = smp_addr_q;
  assign accum_wr_data = '0;
  assign unused_bits   = ^{left_res.votes, right_res.votes};
`else
  assign accum_wr_en   = 1'b0;
  assign accum_wr_addr = '0;
  assign accum_wr_data = '0;
  assign unused_bits   = ^{left_res.votes, right_res.votes, smp_addr_q};
`endif

endmodule
`default_nettype wire

// File: tb/tb_hough_peak_select.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_hough_peak_select                                         |
// | Description : Directed self-checking bench for hough_peak_select with a   |
// |               reduced rho range (RHO_MAX = 4) and a behavioural 1-cycle   |
// |               read-latency accumulator memory.                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_hough_peak_select;

  localparam int THETAS     = 180;
  localparam int RHO_MAX    = 4;
  localparam int NUM_RHOS   = 2 * RHO_MAX + 1;
  localparam int N          = NUM_RHOS * THETAS;
  localparam int ADDR_BITS  = $clog2(N);
  localparam int THETA_BITS = 9;
`ifdef HOUGH_PEAK_CLEAR_EN
  localparam bit CLEAR_MODE = 1'b1;
`else
  localparam bit CLEAR_MODE = 1'b0;
`endif

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic                  accum_done = 1'b0;
  logic [ADDR_BITS-1:0]  accum_rd_addr;
  logic [15:0]           accum_rd_data = '0;
  logic                  accum_wr_en;
  logic [ADDR_BITS-1:0]  accum_wr_addr;
  logic [15:0]           accum_wr_data;
  logic signed [15:0]    left_rho_out;
  logic signed [15:0]    right_rho_out;
  logic [THETA_BITS-1:0] left_theta_out;
  logic [THETA_BITS-1:0] right_theta_out;
  logic                  left_valid;
  logic                  right_valid;
  logic                  busy;
  logic                  hough_done;

  logic [15:0] mem [N];

  int n_checks;
  int n_fail;

  // Output values captured in the cycle hough_done is first seen.
  int snap_lrho, snap_lth, snap_lv, snap_rrho, snap_rth, snap_rv;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    accum_rd_data <= mem[accum_rd_addr];
    if (accum_wr_en) mem[accum_wr_addr] = accum_wr_data;
  end

  hough_peak_select #(
    .THETAS  (THETAS),
    .RHO_MAX (RHO_MAX)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .accum_done      (accum_done),
    .accum_rd_addr   (accum_rd_addr),
    .accum_rd_data   (accum_rd_data),
    .accum_wr_en     (accum_wr_en),
    .accum_wr_addr   (accum_wr_addr),
    .accum_wr_data   (accum_wr_data),
    .left_rho_out    (left_rho_out),
    .right_rho_out   (right_rho_out),
    .left_theta_out  (left_theta_out),
    .right_theta_out (right_theta_out),
    .left_valid      (left_valid),
    .right_valid     (right_valid),
    .busy            (busy),
    .hough_done      (hough_done)
  );

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < N; i++) mem[i] = '0;
  endtask

  task automatic put(input int r, input int t, input int v);
    mem[r * THETAS + t] = 16'(v);
  endtask

  function automatic int count_nonzero();
    int c = 0;
    for (int i = 0; i < N; i++) if (mem[i] != 16'd0) c++;
    return c;
  endfunction

  // Pulses accum_done from a negedge and observes one cycle per negedge.
  // Iteration k observes the k-th cycle after the accum_done cycle.
  task automatic run_scan(input bit dbl, output int lat, output int done_cnt,
                          output int wr_cnt, output int mid_lt);
    int cyc;
    lat      = -1;
    done_cnt = 0;
    wr_cnt   = 0;
    mid_lt   = -1;
    cyc      = 0;
    accum_done = 1'b1;
    while (cyc < N + 60) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) accum_done = 1'b0;
      if (cyc == 10) mid_lt = int'(left_theta_out);
      if (dbl && cyc == 100) accum_done = 1'b1;
      if (dbl && cyc == 101) accum_done = 1'b0;
      if (accum_wr_en) wr_cnt++;
      if (hough_done) begin
        done_cnt++;
        if (lat < 0) begin
          lat       = cyc;
          snap_lrho = int'(left_rho_out);
          snap_lth  = int'(left_theta_out);
          snap_lv   = int'(left_valid);
          snap_rrho = int'(right_rho_out);
          snap_rth  = int'(right_theta_out);
          snap_rv   = int'(right_valid);
        end
      end
      if (lat >= 0 && cyc >= lat + 20) break;
    end
  endtask

  task automatic check_lanes(input string tag, input int lv, input int lrho, input int lth,
                             input int rv, input int rrho, input int rth);
    check({tag, "_left_valid"},  snap_lv,   lv);
    check({tag, "_left_rho"},    snap_lrho, lrho);
    check({tag, "_left_theta"},  snap_lth,  lth);
    check({tag, "_right_valid"}, snap_rv,   rv);
    check({tag, "_right_rho"},   snap_rrho, rrho);
    check({tag, "_right_theta"}, snap_rth,  rth);
  endtask

  initial begin
    int lat, dc, wc, mid, idle_hits;
    n_checks = 0;
    n_fail   = 0;
    clear_mem();

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_hough_done", int'(hough_done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_rd_addr", int'(accum_rd_addr), 0);
    check("rst_left_valid", int'(left_valid), 0);
    check("rst_right_rho", int'(right_rho_out), 0);
    check("rst_wr_en", int'(accum_wr_en), 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_rd_addr", int'(accum_rd_addr), 0);

    // T1: all-zero accumulator
    run_scan(1'b0, lat, dc, wc, mid);
    check("t1_latency", lat, N + 2);
    check("t1_done_count", dc, 1);
    check("t1_wr_count", wc, CLEAR_MODE ? N : 0);
    check_lanes("t1", 0, 0, 0, 0, 0, 0);
    check("t1_busy_after", int'(busy), 0);

    // T2: one peak per lane plus a weaker later left candidate
    clear_mem();
    put(7, 30, 50);
    put(2, 150, 80);
    put(8, 50, 30);
    run_scan(1'b0, lat, dc, wc, mid);
    check("t2_latency", lat, N + 2);
    check_lanes("t2", 1, 3, 30, 1, -2, 150);
    check("t2_wr_count", wc, CLEAR_MODE ? N : 0);
    check("t2_accum_nonzero", count_nonzero(), CLEAR_MODE ? 0 : 3);
    check("t2_hold_left_theta", int'(left_theta_out), 30);

    // T3: window edges 60/170 accepted, 9/61/119/171 ignored
    clear_mem();
    put(0, 9, 100);
    put(0, 61, 100);
    put(5, 60, 25);
    put(0, 171, 99);
    put(0, 119, 90);
    put(8, 170, 21);
    run_scan(1'b0, lat, dc, wc, mid);
    check("t3_mid_scan_hold", mid, 30);
    check_lanes("t3", 1, 1, 60, 1, 4, 170);

    // Reset asserted mid-scan
    clear_mem();
    put(7, 30, 50);
    accum_done = 1'b1;
    @(negedge clock);
    accum_done = 1'b0;
    repeat (50) @(negedge clock);
    check("mid_busy", int'(busy), 1);
    reset = 1'b0;
    @(negedge clock);
    check("mr_busy", int'(busy), 0);
    check("mr_rd_addr", int'(accum_rd_addr), 0);
    check("mr_left_valid", int'(left_valid), 0);
    check("mr_left_rho", int'(left_rho_out), 0);
    check("mr_left_theta", int'(left_theta_out), 0);
    check("mr_right_valid", int'(right_valid), 0);
    check("mr_right_theta", int'(right_theta_out), 0);
    check("mr_wr_en", int'(accum_wr_en), 0);
    reset = 1'b1;
    idle_hits = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (busy || hough_done) idle_hits++;
    end
    check("mr_stays_idle", idle_hits, 0);

    // T4: tie keeps first in scan order; exactly MIN_VOTES at theta 120
    clear_mem();
    put(1, 45, 40);
    put(3, 45, 40);
    put(6, 120, 20);
    run_scan(1'b0, lat, dc, wc, mid);
    check("t4_latency", lat, N + 2);
    check_lanes("t4", 1, -3, 45, 1, 2, 120);

    // T5: below threshold and outside windows; extra accum_done mid-scan
    clear_mem();
    put(3, 40, 19);
    put(4, 90, 200);
    run_scan(1'b1, lat, dc, wc, mid);
    check("t5_latency", lat, N + 2);
    check("t5_done_count", dc, 1);
    check("t5_wr_count", wc, CLEAR_MODE ? N : 0);
    check_lanes("t5", 0, 0, 0, 0, 0, 0);
    check("t5_accum_nonzero", count_nonzero(), CLEAR_MODE ? 0 : 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hough_peak_select.md
# hough_peak_select

Scans the Hough accumulator BRAM after voting completes and selects the strongest line in a left-lane theta window and a right-lane theta window. It sits between the Hough voting stage and the lane highlighter. It outputs signed rho and theta for each lane, held stable until the next scan, and pulses `hough_done` to start the highlighter. It optionally clears the accumulator as it scans, so the next frame can vote without a separate clear pass.

## Interface
- `THETAS`, 180: theta bins, 1°/bin.
- `RHO_MAX`, 1468: rho range is −RHO_MAX..+RHO_MAX, giving NUM_RHOS = 2·RHO_MAX+1.
- `ACCUM_BITS`, 16: vote count width.
- `THETA_BITS`, 9: theta output width.
- `LEFT_THETA_MIN` / `LEFT_THETA_MAX`, 10 / 60: inclusive left-lane window.
- `RIGHT_THETA_MIN` / `RIGHT_THETA_MAX`, 120 / 170: inclusive right-lane window.
- `MIN_VOTES`, 20: a candidate must satisfy votes ≥ MIN_VOTES.
- `ADDR_BITS`, $clog2(NUM_RHOS·THETAS): accumulator address width.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `accum_done` in 1: one-cycle pulse; voting finished.
- `accum_rd_addr` out ADDR_BITS: address = rho_idx·THETAS + theta.
- `accum_rd_data` in ACCUM_BITS: valid exactly 1 cycle after the address.
- `accum_wr_en` out 1: clear write enable (HOUGH_PEAK_CLEAR_EN only).
- `accum_wr_addr` out ADDR_BITS: clear address.
- `accum_wr_data` out ACCUM_BITS: always 0.
- `left_rho_out`, `right_rho_out` out 16 signed: rho_idx − RHO_MAX.
- `left_theta_out`, `right_theta_out` out THETA_BITS: selected theta.
- `left_valid`, `right_valid` out 1: a peak ≥ MIN_VOTES was found.
- `busy` out 1: high from the cycle after `accum_done` until the cycle `hough_done` asserts.
- `hough_done` out 1: one-cycle pulse; outputs are valid.

## Operation
- States: IDLE → SCAN → DRAIN → DONE → IDLE.
- IDLE: `accum_done` = 1 → SCAN. The scan counters (rho_idx, theta) clear to 0 and both best-vote registers clear to 0.
- SCAN: issue one read address per cycle, theta innermost. Theta wraps at THETAS−1 to 0 and increments rho_idx. After issuing the last address (NUM_RHOS−1, THETAS−1), go to DRAIN.
- Read pipeline: the issued (rho_idx, theta) pair is registered for 1 cycle and paired with the returning `accum_rd_data`.
- Compare on each returned sample:
  - If theta is in the left window and data > left_best and data ≥ MIN_VOTES, update left_best, left rho and left theta.
  - Apply the same rule in the right window.
  - A theta outside both windows is ignored.
  - The comparison is strict, so the first occurrence in scan order wins a tie.
- DRAIN: 1 cycle to consume the final sample → DONE.
- DONE: assert `hough_done` for 1 cycle, set the valid flags from the scan result, → IDLE.
- Output registers (`*_rho_out`, `*_theta_out`, `*_valid`):
  - Updated only in DONE, so they stay stable during the next scan.
  - A lane with no candidate has valid = 0, rho = 0, theta = 0.
- `accum_done` is ignored outside IDLE; it is neither queued nor restarted.
- Arithmetic:
  - rho = signed 16-bit of (rho_idx − RHO_MAX).
  - Vote comparisons are unsigned, ACCUM_BITS wide.
- Reset mid-scan: return to IDLE immediately. All outputs return to reset values. Any partial clear is left as is.

## Timing
- Reset values: every output is 0; state is IDLE.
- The first read address is issued the cycle after `accum_done`.
- Total latency from `accum_done` to `hough_done` = NUM_RHOS·THETAS + 2 cycles.
- Outputs change in the same cycle `hough_done` is high, and are readable from that cycle.
- `accum_rd_addr` holds 0 while IDLE.

## Configuration
- `HOUGH_PEAK_CLEAR_EN` defined:
  - In the cycle a sample returns, drive `accum_wr_en` = 1 with `accum_wr_addr` = that sample's address and `accum_wr_data` = 0.
  - The BRAM must be dual-port. The write targets an address already read, so there is no read-after-write hazard.
- Undefined: `accum_wr_en`, `accum_wr_addr` and `accum_wr_data` are tied to 0, and the accumulator is untouched.

## Structure
- Shared package `hough_pkg` holds:
  - THETAS, RHO_MAX and NUM_RHOS.
  - The theta window constants.
  - The state enum typedef.
  - A `lane_peak_t` struct {votes, rho, theta, valid}.
- One sub-module, `peak_tracker`, instantiated twice (left, right):
  - Parameterized by window min/max.
  - Takes the sample, rho and theta; holds the running best.
  - Has a clear input and a result output.

## Test plan
- All-zero accumulator, `accum_done` pulse → `hough_done` pulses after NUM_RHOS·180 + 2 cycles; both valid = 0.
- Votes: 50 at (rho_idx=1500, θ=30) and 80 at (rho_idx=1400, θ=150) → left rho=32, θ=30; right rho=−68, θ=150; both valid.
- Tie: 40 at rho_idx 100 and 40 at rho_idx 200, both at θ=45 → left rho=100−1468=−1368, i.e. the first one in scan order.
- Vote 19 (< MIN_VOTES) at θ=40, and 200 at θ=90 (outside both windows) → left_valid = 0, right_valid = 0.
- Second `accum_done` pulse mid-scan → ignored; exactly one `hough_done`. Reset asserted mid-scan → all outputs 0 and state IDLE on the next edge.
- With HOUGH_PEAK_CLEAR_EN: after a scan, every address reads 0, and the `accum_wr_en` count = NUM_RHOS·180.
